clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Controller for the 24-hour BCD time-of-day counter (hh/mm/ss registers with a loadable interface).
- Generates the once-per-second enable tick that advances the counter.
- Runs a button-driven set-mode FSM that edits and loads hours and minutes.
- Holds an alarm time and raises a latched ring output on match; sits between the user-input conditioner (debounced, single-cycle button pulses) and the time counter.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 s tick (min 2)
- ALARM_RST, 16'h0700, BCD {hh,mm} alarm value loaded at reset
- RING_SEC, 60, ticks after which an unacknowledged ring self-clears (min 1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- btn_mode  in  1  one-cycle pulse, advance set mode / acknowledge ring
- btn_inc  in  1  one-cycle pulse, increment field being edited / acknowledge ring
- alarm_en  in  1  level, alarm armed
- cur_hh  in  8  BCD hours from time counter (00-23)
- cur_mm  in  8  BCD minutes (00-59)
- cur_ss  in  8  BCD seconds (00-59)
- tick  out  1  one-cycle enable to time counter
- ld  out  1  one-cycle load strobe to time counter
- ld_hh  out  8  BCD hours to load, valid with ld
- ld_mm  out  8  BCD minutes to load, valid with ld
- ld_ss  out  8  BCD seconds to load, constant 8'h00
- mode  out  3  current FSM state, for display
- edit_hh  out  8  BCD hours being edited
- edit_mm  out  8  BCD minutes being edited
- al_hh  out  8  BCD alarm hours
- al_mm  out  8  BCD alarm minutes
- ring  out  1  alarm active

Behaviour:
- Reset (sync, active-high, clk rising edge):
  - state RUN; tick, ld, ring = 0; prescaler = 0; ring counter = 0
  - edit_hh, edit_mm, ld_hh, ld_mm = 8'h00
  - {al_hh, al_mm} = ALARM_RST
  - Reset mid-edit discards the edits; no ld is issued.
- States and encodings: RUN = 0, SET_HH = 1, SET_MM = 2, SET_AH = 3, SET_AM = 4.
- Transitions on btn_mode: RUN -> SET_HH -> SET_MM -> SET_AH -> SET_AM -> RUN.
- RUN -> SET_HH: edit_hh <= cur_hh, edit_mm <= cur_mm in the same edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps. tick is registered: high for exactly one cycle when the count wraps.
  - In SET_HH and SET_MM the prescaler is held at 0 and tick = 0, freezing the clock.
  - In RUN, SET_AH and SET_AM it runs normally.
- btn_inc, BCD arithmetic with wrap:
  - SET_HH: edit_hh 09 -> 10, 19 -> 20, 23 -> 00.
  - SET_MM: edit_mm 09 -> 10, 59 -> 00.
  - SET_AH: al_hh, same rule as hours.
  - SET_AM: al_mm, same rule as minutes.
  - RUN: no effect.
  - Nibbles never hold A-F.
- Load on SET_MM -> SET_AH:
  - ld = 1 for exactly one cycle, the cycle after btn_mode is sampled.
  - ld_hh = edit_hh, ld_mm = edit_mm, ld_ss = 00.
  - Prescaler restarts from 0, so the first tick follows TICK_DIV cycles later.
  - ld and tick are never high in the same cycle.
- Simultaneous btn_mode and btn_inc: btn_mode wins; btn_inc is dropped.
- Alarm match:
  - match = alarm_en && cur_hh == al_hh && cur_mm == al_mm && cur_ss == 00.
  - ring sets on the rising edge of match (registered match_d), in any state.
  - A match already true at reset release does not ring until the next rising edge.
- Ring clear, any of:
  - btn_mode or btn_inc while ring = 1. That press is consumed: no state change, no increment.
  - alarm_en = 0; clears in the next cycle.
  - RING_SEC ticks elapsed since ring set.
- A ring set and a press in the same cycle: set wins; the press is consumed.

Decomposition:
- Shared package clock_pkg:
  - State enum and encodings.
  - Constants BCD_HH_MAX = 8'h23 and BCD_MM_MAX = 8'h59.
  - Function bcd_inc_wrap(value, max), returning 00 when value == max, otherwise BCD +1.
- One sub-module, tick_prescaler (parameter TICK_DIV; inputs clk, reset, run, restart; output tick), instantiated once.

Test Plan (TICK_DIV = 4, RING_SEC = 3, ALARM_RST = 16'h0700):
- Free run: release reset, 12 cycles in RUN -> tick pulses on cycles 4, 8, 12; ld stays 0; mode = 0.
- Set time: cur = 22:58:30; btn_mode, 2x btn_inc, btn_mode, 2x btn_inc, btn_mode -> edit_hh 23 then 00 (wrap); edit_mm 59 then 00; one-cycle ld with ld_hh = 00, ld_mm = 00, ld_ss = 00; no tick while mode is 1 or 2; mode = 3 after load.
- Hour BCD carry: edit_hh = 09 in SET_HH, btn_inc -> 10; from 19, btn_inc -> 20; no A-F nibble ever appears.
- Simultaneous buttons: btn_mode and btn_inc together in SET_HH with edit_hh = 05 -> mode = 2, edit_hh stays 05.
- Alarm: alarm_en = 1, cur moves 06:59:59 -> 07:00:00 -> ring = 1 next cycle. btn_inc -> ring = 0, mode unchanged. Repeat without press -> ring self-clears after 3 ticks.
- Reset mid-edit: in SET_MM with edit_mm = 42, assert reset 1 cycle -> mode = 0, edit regs 00, al = 07:00, no ld pulse.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and BCD helpers for the time-of-day set controller.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
  } hm_t;

  localparam logic [7:0] BCD_HH_MAX = 8'h23;
  localparam logic [7:0] BCD_MM_MAX = 8'h59;

  // BCD +1 with wrap to 00 once max is reached; never produces an A-F nibble.
  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] value, input logic [7:0] max);
    if (value == max) return 8'h00;
    if (value[3:0] == 4'h9) return {value[7:4] + 4'h1, 4'h0};
    return value + 8'h01;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Link between the set controller (master) and the BCD time counter (slave).
interface clock_set_ctrl_if;
  logic [7:0] cur_hh;
  logic [7:0] cur_mm;
  logic [7:0] cur_ss;
  logic       tick;
  logic       ld;
  logic [7:0] ld_hh;
  logic [7:0] ld_mm;
  logic [7:0] ld_ss;

  modport master (
    input  cur_hh, cur_mm, cur_ss,
    output tick, ld, ld_hh, ld_mm, ld_ss
  );

  modport slave (
    output cur_hh, cur_mm, cur_ss,
    input  tick, ld, ld_hh, ld_mm, ld_ss
  );
endinterface

// File: rtl/clock_set_ctrl_tick_prescaler.sv
// Divides clk down to a registered one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !run || restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode FSM, 1 s tick generation and alarm ring for the BCD time-of-day counter.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int          TICK_DIV  = 50000000,
  parameter logic [15:0] ALARM_RST = 16'h0700,
  parameter int          RING_SEC  = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             alarm_en,
  clock_set_ctrl_if.master tc,
  output logic [2:0]       mode,
  output logic [7:0]       edit_hh,
  output logic [7:0]       edit_mm,
  output logic [7:0]       al_hh,
  output logic [7:0]       al_mm,
  output logic             ring
);
  localparam int RCW = $clog2(RING_SEC + 1);

  state_t     state, state_nx;
  logic [7:0] edit_hh_nx, edit_mm_nx;
  hm_t        al, al_nx;
  logic       ld_nx, ld_q;
  logic [7:0] ld_hh_q, ld_mm_q;
  logic       tick;
  logic       match, match_d, rise, consume, press_mode, press_inc;
  logic [RCW-1:0] ring_cnt;

  // A press while ringing (or as the ring starts) only acknowledges the alarm.
  always_comb begin
    match      = alarm_en && (tc.cur_hh == al.hh) && (tc.cur_mm == al.mm) && (tc.cur_ss == 8'h00);
    rise       = match && !match_d;
    consume    = ring || rise;
    press_mode = btn_mode && !consume;
    press_inc  = btn_inc && !btn_mode && !consume;
  end

  always_comb begin
    state_nx   = state;
    edit_hh_nx = edit_hh;
    edit_mm_nx = edit_mm;
    al_nx      = al;
    ld_nx      = 1'b0;
    case (state)
      RUN: if (press_mode) begin
        state_nx   = SET_HH;
        edit_hh_nx = tc.cur_hh;
        edit_mm_nx = tc.cur_mm;
      end
      SET_HH:
        if (press_mode)     state_nx   = SET_MM;
        else if (press_inc) edit_hh_nx = bcd_inc_wrap(edit_hh, BCD_HH_MAX);
      SET_MM:
        if (press_mode) begin
          state_nx = SET_AH;
          ld_nx    = 1'b1;
        end else if (press_inc) edit_mm_nx = bcd_inc_wrap(edit_mm, BCD_MM_MAX);
      SET_AH:
        if (press_mode)     state_nx = SET_AM;
        else if (press_inc) al_nx.hh = bcd_inc_wrap(al.hh, BCD_HH_MAX);
      SET_AM:
        if (press_mode)     state_nx = RUN;
        else if (press_inc) al_nx.mm = bcd_inc_wrap(al.mm, BCD_MM_MAX);
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      edit_hh <= 8'h00;
      edit_mm <= 8'h00;
      al      <= ALARM_RST;
      ld_q    <= 1'b0;
      ld_hh_q <= 8'h00;
      ld_mm_q <= 8'h00;
    end else begin
      state   <= state_nx;
      edit_hh <= edit_hh_nx;
      edit_mm <= edit_mm_nx;
      al      <= al_nx;
      ld_q    <= ld_nx;
      if (ld_nx) begin
        ld_hh_q <= edit_hh;
        ld_mm_q <= edit_mm;
      end
    end
  end

  // match_d tracks match through reset so a match present at release does not ring.
  always_ff @(posedge clk) begin
    match_d <= match;
    if (reset) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (rise) begin
      ring     <= 1'b1;
      ring_cnt <= '0;
    end else if (ring) begin
      if (btn_mode || btn_inc || !alarm_en) ring <= 1'b0;
      else if (tick) begin
        if (ring_cnt == RCW'(RING_SEC - 1)) ring <= 1'b0;
        else ring_cnt <= ring_cnt + 1'b1;
      end
    end
  end

  // Freeze decided on the next state so no tick leaks into the first edit cycle.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk     (clk),
    .reset   (reset),
    .run     ((state_nx != SET_HH) && (state_nx != SET_MM)),
    .restart (ld_nx),
    .tick    (tick)
  );

  assign tc.tick  = tick;
  assign tc.ld    = ld_q;
  assign tc.ld_hh = ld_hh_q;
  assign tc.ld_mm = ld_mm_q;
  assign tc.ld_ss = 8'h00;
  assign mode     = state;
  assign al_hh    = al.hh;
  assign al_mm    = al.mm;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed scenarios plus randomized traffic against a decimal reference model.
module tb_clock_set_ctrl;
  localparam int          TD = 4;
  localparam int          RS = 3;
  localparam logic [15:0] AR = 16'h0700;

  logic       clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0, alarm_en = 1'b0;
  logic [2:0] mode;
  logic [7:0] edit_hh, edit_mm, al_hh, al_mm;
  logic       ring;
  int         passed = 0, total = 0;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.TICK_DIV(TD), .ALARM_RST(AR), .RING_SEC(RS)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .alarm_en(alarm_en),
    .tc(bus), .mode(mode), .edit_hh(edit_hh), .edit_mm(edit_mm),
    .al_hh(al_hh), .al_mm(al_mm), .ring(ring)
  );

  always #5 clk = ~clk;

  // reference model: decimal fields, mode as 0..4 sequence
  int m_mode, e_h, e_m, a_h, a_m, pcnt, l_h, l_m, rcnt;
  bit m_tick, m_ld, m_ring, m_md;

  function automatic logic [7:0] bcd(input int d);
    return 8'((d / 10) * 16 + d % 10);
  endfunction
  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic model_update();
    bit match, rise, pm, pi, ld, nring, ntick;
    int nm, nrcnt;
    match = alarm_en && bus.cur_hh == bcd(a_h) && bus.cur_mm == bcd(a_m) && bus.cur_ss == 8'h00;
    if (reset) begin
      m_mode = 0; e_h = 0; e_m = 0; a_h = dec(AR[15:8]); a_m = dec(AR[7:0]);
      pcnt = 0; m_tick = 0; m_ld = 0; l_h = 0; l_m = 0; m_ring = 0; rcnt = 0; m_md = match;
      return;
    end
    rise = match && !m_md;
    pm = btn_mode && !(m_ring || rise);
    pi = btn_inc && !btn_mode && !(m_ring || rise);
    nm = pm ? (m_mode + 1) % 5 : m_mode;
    ld = (m_mode == 2) && pm;
    nring = m_ring; nrcnt = rcnt;
    if (rise) begin nring = 1; nrcnt = 0; end
    else if (m_ring) begin
      if (btn_mode || btn_inc || !alarm_en) nring = 0;
      else if (m_tick) begin nrcnt = rcnt + 1; if (nrcnt == RS) nring = 0; end
    end
    if (nm == 1 || nm == 2 || ld) begin pcnt = 0; ntick = 0; end
    else begin pcnt++; ntick = (pcnt == TD); if (ntick) pcnt = 0; end
    if (ld) begin l_h = e_h; l_m = e_m; end
    if (m_mode == 0 && pm) begin e_h = dec(bus.cur_hh); e_m = dec(bus.cur_mm); end
    if (pi) case (m_mode)
      1: e_h = (e_h + 1) % 24;
      2: e_m = (e_m + 1) % 60;
      3: a_h = (a_h + 1) % 24;
      4: a_m = (a_m + 1) % 60;
      default: ;
    endcase
    m_mode = nm; m_ld = ld; m_tick = ntick; m_ring = nring; rcnt = nrcnt; m_md = match;
  endtask

  task automatic step(input logic bm, input logic bi);
    @(negedge clk);
    btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.cur_hh = h; bus.cur_mm = m; bus.cur_ss = s;
  endtask

  task automatic test_reset();
    reset = 1'b1; set_cur(8'h00, 8'h00, 8'h00);
    step(0, 0); step(0, 0);
    total++; if (mode !== 3'd0) $display("FAIL reset_mode got %0d want 0", mode); else passed++;
    total++; if ({bus.tick, bus.ld, ring} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {bus.tick, bus.ld, ring}); else passed++;
    total++; if ({edit_hh, edit_mm, bus.ld_hh, bus.ld_mm, bus.ld_ss} !== 40'h0) $display("FAIL reset_regs got %h want 0", {edit_hh, edit_mm, bus.ld_hh, bus.ld_mm, bus.ld_ss}); else passed++;
    total++; if ({al_hh, al_mm} !== 16'h0700) $display("FAIL reset_alarm got %h want 0700", {al_hh, al_mm}); else passed++;
  endtask

  task automatic test_free_run();
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step(0, 0);
      total++; if (bus.tick !== (c % 4 == 0)) $display("FAIL free_tick c%0d got %b want %b", c, bus.tick, (c % 4 == 0)); else passed++;
      total++; if (bus.ld !== 1'b0 || mode !== 3'd0) $display("FAIL free_ld_mode c%0d got %b/%0d want 0/0", c, bus.ld, mode); else passed++;
    end
  endtask

  task automatic test_set_time();
    logic       sm [7] = '{1, 0, 0, 1, 0, 0, 1};
    logic       si [7] = '{0, 1, 1, 0, 1, 1, 0};
    logic [7:0] xh [7] = '{8'h22, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] xm [7] = '{8'h58, 8'h58, 8'h58, 8'h58, 8'h59, 8'h00, 8'h00};
    logic [2:0] xs [7] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
    set_cur(8'h22, 8'h58, 8'h30);
    for (int k = 0; k < 7; k++) begin
      step(sm[k], si[k]);
      total++; if ({mode, edit_hh, edit_mm} !== {xs[k], xh[k], xm[k]}) $display("FAIL set_edit k%0d got %0d %h:%h want %0d %h:%h", k, mode, edit_hh, edit_mm, xs[k], xh[k], xm[k]); else passed++;
      total++; if (bus.ld !== (k == 6)) $display("FAIL set_ld k%0d got %b want %b", k, bus.ld, (k == 6)); else passed++;
      total++; if (bus.tick !== 1'b0) $display("FAIL set_frozen_tick k%0d got %b want 0", k, bus.tick); else passed++;
    end
    total++; if ({bus.ld_hh, bus.ld_mm, bus.ld_ss} !== 24'h000000) $display("FAIL set_ld_value got %h want 000000", {bus.ld_hh, bus.ld_mm, bus.ld_ss}); else passed++;
    for (int k = 1; k <= 4; k++) begin
      step(0, 0);
      total++; if ({bus.ld, bus.tick} !== {1'b0, k == 4}) $display("FAIL set_after_ld k%0d got %b want %b", k, {bus.ld, bus.tick}, {1'b0, k == 4}); else passed++;
    end
  endtask

  task automatic test_hour_carry();
    bit bad = 0;
    step(1, 0); step(1, 0);
    total++; if (mode !== 3'd0) $display("FAIL carry_back_run got %0d want 0", mode); else passed++;
    set_cur(8'h09, 8'h00, 8'h00);
    step(1, 0); step(0, 1);
    total++; if (edit_hh !== 8'h10) $display("FAIL carry_09 got %h want 10", edit_hh); else passed++;
    for (int k = 0; k < 9; k++) begin step(0, 1); if (edit_hh[3:0] > 4'h9 || edit_hh[7:4] > 4'h9) bad = 1; end
    step(0, 1);
    total++; if (edit_hh !== 8'h20) $display("FAIL carry_19 got %h want 20", edit_hh); else passed++;
    for (int k = 0; k < 9; k++) begin step(0, 1); if (edit_hh[3:0] > 4'h9 || edit_hh[7:4] > 4'h9) bad = 1; end
    total++; if (edit_hh !== 8'h05 || bad) $display("FAIL carry_wrap_nibbles got %h bad=%0d want 05 bad=0", edit_hh, bad); else passed++;
  endtask

  task automatic test_simultaneous();
    step(1, 1);
    total++; if ({mode, edit_hh} !== {3'd2, 8'h05}) $display("FAIL simul got %0d/%h want 2/05", mode, edit_hh); else passed++;
    step(1, 0); step(1, 0); step(1, 0);
    total++; if (mode !== 3'd0) $display("FAIL simul_back_run got %0d want 0", mode); else passed++;
  endtask

  task automatic test_alarm();
    int n, guard;
    alarm_en = 1'b1;
    set_cur(8'h06, 8'h59, 8'h59); step(0, 0);
    total++; if (ring !== 1'b0) $display("FAIL alarm_premature got %b want 0", ring); else passed++;
    set_cur(8'h07, 8'h00, 8'h00); step(0, 0);
    total++; if (ring !== 1'b1) $display("FAIL alarm_set got %b want 1", ring); else passed++;
    step(0, 1);
    total++; if ({ring, mode} !== {1'b0, 3'd0}) $display("FAIL alarm_ack got %b/%0d want 0/0", ring, mode); else passed++;
    step(0, 0);
    total++; if (ring !== 1'b0) $display("FAIL alarm_stay_clear got %b want 0", ring); else passed++;
    set_cur(8'h06, 8'h59, 8'h59); step(0, 0);
    set_cur(8'h07, 8'h00, 8'h00); step(0, 0);
    total++; if (ring !== 1'b1) $display("FAIL alarm_reset2 got %b want 1", ring); else passed++;
    n = (ring && bus.tick) ? 1 : 0; guard = 0;
    while (ring && guard < 40) begin step(0, 0); guard++; if (ring && bus.tick) n++; end
    total++; if (ring !== 1'b0 || n != RS) $display("FAIL alarm_timeout got ring=%b ticks=%0d want ring=0 ticks=%0d", ring, n, RS); else passed++;
    set_cur(8'h06, 8'h59, 8'h59); step(0, 0);
    set_cur(8'h07, 8'h00, 8'h00); step(0, 0);
    alarm_en = 1'b0; step(0, 0);
    total++; if (ring !== 1'b0) $display("FAIL alarm_disable got %b want 0", ring); else passed++;
  endtask

  task automatic test_reset_mid_edit();
    bit ld_seen = 0;
    set_cur(8'h10, 8'h42, 8'h00);
    step(1, 0); step(1, 0);
    total++; if ({mode, edit_mm} !== {3'd2, 8'h42}) $display("FAIL mid_setup got %0d/%h want 2/42", mode, edit_mm); else passed++;
    reset = 1'b1; step(0, 0); reset = 1'b0;
    total++; if ({mode, edit_hh, edit_mm, al_hh, al_mm} !== {3'd0, 8'h00, 8'h00, 8'h07, 8'h00}) $display("FAIL mid_reset got %0d %h %h %h %h want 0 00 00 07 00", mode, edit_hh, edit_mm, al_hh, al_mm); else passed++;
    if (bus.ld) ld_seen = 1;
    for (int k = 0; k < 4; k++) begin step(0, 0); if (bus.ld) ld_seen = 1; end
    total++; if (ld_seen) $display("FAIL mid_no_ld got ld pulse want none"); else passed++;
  endtask

  task automatic test_random();
    logic bm, bi;
    for (int k = 0; k < 800; k++) begin
      reset = ($urandom_range(199) == 0);
      if ($urandom_range(49) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(2) == 0) set_cur(bcd(a_h), bcd(a_m), ($urandom_range(1) == 0) ? 8'h00 : 8'h01);
      else set_cur(bcd($urandom_range(23)), bcd($urandom_range(59)), bcd($urandom_range(59)));
      bm = ($urandom_range(5) == 0);
      bi = ($urandom_range(3) == 0);
      step(bm, bi);
      total++;
      if ({mode, edit_hh, edit_mm, al_hh, al_mm, bus.tick, bus.ld, bus.ld_hh, bus.ld_mm, bus.ld_ss, ring} !==
          {3'(m_mode), bcd(e_h), bcd(e_m), bcd(a_h), bcd(a_m), m_tick, m_ld, bcd(l_h), bcd(l_m), 8'h00, m_ring})
        $display("FAIL random k%0d got mode=%0d e=%h:%h a=%h:%h t=%b ld=%b %h:%h:%h r=%b want mode=%0d e=%h:%h a=%h:%h t=%b ld=%b %h:%h:00 r=%b",
                 k, mode, edit_hh, edit_mm, al_hh, al_mm, bus.tick, bus.ld, bus.ld_hh, bus.ld_mm, bus.ld_ss, ring,
                 m_mode, bcd(e_h), bcd(e_m), bcd(a_h), bcd(a_m), m_tick, m_ld, bcd(l_h), bcd(l_m), m_ring);
      else passed++;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_set_time();
    test_hour_carry();
    test_simultaneous();
    test_alarm();
    test_reset_mid_edit();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
